lsu_mmio: RTL and testbench
===========================

// Module: lsu_mmio
// PURPOSE
//  Parametrised RV32I load/store unit: byte-enabled data memory plus memory-mapped IO.
//  Adds the following:
//   - LB/LH/LW/LBU/LHU loads and SB/SH/SW stores.
//   - Misalignment and unmapped-access faults.
//   - Read-back of output registers.
//   - 2-flop synchronisers on switch and key inputs.
//  Sits between the execute stage and the board peripherals (HEX, LEDR, LEDG, LCD, SW, KEYS).
// PARAMETERS
//  ADDR_W      12   byte-address width; the block decodes addr_i[ADDR_W-1:0] only
//  DMEM_WORDS  512  data memory depth in 32-bit words (2 KiB); power of two, <= 512
//  NUM_HEX     8    HEX output registers instantiated, 1..8
//  SYNC_STAGES 2    synchroniser depth on io_sw_i / io_keys_i, >= 2
// PORTS
//  clk             in   1           rising-edge clock
//  rst_ni          in   1           asynchronous active-low reset
//  addr_i          in   ADDR_W      byte address
//  ld_st_sel_i     in   3           funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  st_en_i         in   1           store strobe, sampled at posedge
//  st_data_i       in   32          store data, right-aligned
//  ld_data_o       out  32          registered load data, extended per ld_st_sel_i
//  misalign_o      out  1           registered: access at addr_i is misaligned
//  fault_o         out  1           registered: addr_i unmapped or ld_st_sel_i illegal
//  io_sw_i         in   32          switches, asynchronous
//  io_keys_i       in   32          keys, asynchronous
//  io_hex_o        out  NUM_HEX*32  HEX regs; hex k occupies bits [32k+31:32k]
//  io_ledr_o       out  32          red LEDs
//  io_ledg_o       out  32          green LEDs
//  io_lcd_o        out  32          LCD register
// BEHAVIOUR
//  Memory map (12-bit view):
//   - 0x000-0x7FF: DMEM; word index addr[10:2] mod DMEM_WORDS.
//   - 0x800 + 0x10*k: HEX k, for k < NUM_HEX.
//   - 0x880 LEDR; 0x890 LEDG; 0x8A0 LCD.
//   - 0x900 SW (read-only); 0x910 KEYS (read-only).
//   - Within an IO slot, addr[3:2] must be 0; addr[1:0] selects bytes.
//   - Everything else is unmapped.
//  Reset:
//   - All IO output registers, ld_data_o, misalign_o, fault_o and the synchroniser flops are 0.
//   - DMEM is not reset.
//  Load latency:
//   - addr_i/ld_st_sel_i held during cycle N -> ld_data_o valid after posedge N+1.
//   - The load path is always active; no enable.
//  Alignment:
//   - H requires addr[0]=0; W requires addr[1:0]=0; B is always aligned.
//   - Misaligned access: misalign_o=1, ld_data_o=0, store suppressed.
//  Byte lanes:
//   - Store byte enables = 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W).
//   - Data is replicated across lanes.
//   - Byte enables apply equally to DMEM and IO registers.
//  Extension:
//   - B/H sign-extend; BU/HU zero-extend; lane selected by addr[1:0].
//  Read/write behaviour:
//   - Output IO registers read back their current value.
//   - SW/KEYS reads return the last synchroniser stage.
//   - Stores to SW/KEYS set fault_o and are ignored.
//   - Unmapped or illegal funct3 (011, 11x): fault_o=1, ld_data_o=0, no state change.
//   - funct3 10x combined with st_en_i is illegal.
//  Simultaneous load and store to the same location is read-first:
//   - ld_data_o shows pre-store contents.
//   - The new value is visible on the next load.
//  IO outputs update at the posedge that samples st_en_i=1; no extra delay.
//  Input latency: an io_sw_i change is readable after SYNC_STAGES edges, plus 1 load cycle.
//  Reset asserted mid-store: the store is lost; IO regs and outputs go to 0 immediately (async).
//  misalign_o and fault_o are never both 1; misalignment takes priority over unmapped.
// STRUCTURE
//  Shared package lsu_pkg:
//   - funct3 enum: LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
//   - Region base constants: DMEM_BASE, HEX_BASE, LEDR_ADDR, LEDG_ADDR, LCD_ADDR, SW_ADDR, KEYS_ADDR.
//   - byte_en(funct3, addr_lo) function.
//  Sub-module lsu_dmem:
//   - Synchronous single-port RAM, DMEM_WORDS x 32, 4 byte-write enables.
//   - Read-first; no reset.
//  Top level holds decode, IO regs, synchronisers, load mux and extension.
// TESTING
//  1 SW 0x004 <- 0xDEADBEEF; LW 0x004 -> ld_data_o=0xDEADBEEF one cycle later, misalign_o=0, fault_o=0.
//  2 SB 0x011 <- 0x000000A5 over word 0x11223344:
//     - LW 0x010 -> 0x1122A544.
//     - LB 0x011 -> 0xFFFFFFA5.
//     - LBU 0x011 -> 0x000000A5.
//     - LHU 0x012 -> 0x00001122.
//  3 LW 0x006 -> misalign_o=1, ld_data_o=0; SH 0x003 <- 0xFFFF -> word at 0x000 unchanged.
//  4 SW 0x800..0x870, 0x880, 0x890, 0x8A0 with distinct values:
//     - Each output reflects its value the cycle after the store.
//     - LW at the same address reads it back.
//     - NUM_HEX=4: a store to 0x840 sets fault_o=1 and changes no output.
//  5 io_sw_i=0x12345678 held:
//     - LW 0x900 returns 0x12345678 by the 3rd edge, not before.
//     - SW 0x910 <- 0xFFFFFFFF sets fault_o=1; a KEYS read is unchanged.
//  6 Write LEDR=0xFFFFFFFF, then pulse rst_ni low mid-cycle:
//     - io_ledr_o=0 before the next clk edge.
//     - LW 0xA00 (unmapped) -> fault_o=1, ld_data_o=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, memory-map constants and lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  localparam logic [11:0] DMEM_BASE = 12'h000;
  localparam logic [11:0] HEX_BASE  = 12'h800;
  localparam logic [11:0] LEDR_ADDR = 12'h880;
  localparam logic [11:0] LEDG_ADDR = 12'h890;
  localparam logic [11:0] LCD_ADDR  = 12'h8A0;
  localparam logic [11:0] SW_ADDR   = 12'h900;
  localparam logic [11:0] KEYS_ADDR = 12'h910;

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   byte_en = 4'b0001 << addr_lo;
      2'b01:   byte_en = 4'b0011 << addr_lo;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Right-aligned store data copied into every lane it may land on.
  function automatic logic [31:0] st_replicate(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3[1:0])
      2'b00:   st_replicate = {4{data[7:0]}};
      2'b01:   st_replicate = {2{data[15:0]}};
      default: st_replicate = data;
    endcase
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      be_merge[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] ld_extend(input logic [31:0] word, input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic [31:0] sh;
    sh = word >> {addr_lo, 3'b000};
    case (funct3)
      LSU_B:   ld_extend = {{24{sh[7]}}, sh[7:0]};
      LSU_H:   ld_extend = {{16{sh[15]}}, sh[15:0]};
      LSU_BU:  ld_extend = {24'b0, sh[7:0]};
      LSU_HU:  ld_extend = {16'b0, sh[15:0]};
      default: ld_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Single-port synchronous data RAM with per-byte write enables; read-first, no reset.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int unsigned WORDS = 512,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [3:0]       i_be,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lsu_mmio.sv
// RV32I load/store unit: decodes DMEM and board IO, holds IO registers and input synchronisers.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DMEM_WORDS  = 512,
  parameter int unsigned NUM_HEX     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [2:0]           ld_st_sel_i,
  input  logic                 st_en_i,
  input  logic [31:0]          st_data_i,
  output logic [31:0]          ld_data_o,
  output logic                 misalign_o,
  output logic                 fault_o,
  input  logic [31:0]          io_sw_i,
  input  logic [31:0]          io_keys_i,
  output logic [NUM_HEX*32-1:0] io_hex_o,
  output logic [31:0]          io_ledr_o,
  output logic [31:0]          io_ledg_o,
  output logic [31:0]          io_lcd_o
);

  localparam int unsigned IDX_W = $clog2(DMEM_WORDS);

  logic [11:0] w_a;
  logic        w_hi_ok;
  logic [2:0]  w_f3;
  logic        w_f3_legal;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_slot_ok;
  logic        w_is_dmem;
  logic        w_is_hex;
  logic        w_is_ledr;
  logic        w_is_ledg;
  logic        w_is_lcd;
  logic        w_is_sw;
  logic        w_is_keys;
  logic        w_mapped;
  logic        w_fault;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_io_rdata;
  logic [31:0] w_dmem_rdata;
  logic [31:0] w_ld_word;

  logic [31:0] r_hex [NUM_HEX];
  logic [31:0] r_ledr;
  logic [31:0] r_ledg;
  logic [31:0] r_lcd;
  logic [31:0] r_sw_sync [SYNC_STAGES];
  logic [31:0] r_keys_sync [SYNC_STAGES];
  logic        r_misalign;
  logic        r_fault;
  logic        r_ld_zero;
  logic        r_ld_dmem;
  logic [2:0]  r_ld_f3;
  logic [1:0]  r_ld_lo;
  logic [31:0] r_io_rdata;

  assign w_a     = addr_i[11:0];
  assign w_hi_ok = ((addr_i >> 12) == '0);
  assign w_f3    = ld_st_sel_i;

  always_comb begin
    w_f3_legal = 1'b0;
    case (w_f3)
      LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: w_f3_legal = 1'b1;
      default:                             w_f3_legal = 1'b0;
    endcase
  end

  // Misalignment only judged for legal sizes; it outranks every fault cause.
  assign w_misalign = w_f3_legal &&
                      (((w_f3[1:0] == 2'b01) && w_a[0]) ||
                       ((w_f3[1:0] == 2'b10) && (w_a[1:0] != 2'b00)));
  assign w_illegal  = !w_f3_legal || (st_en_i && w_f3[2]);

  assign w_slot_ok = w_hi_ok && w_a[11] && (w_a[3:2] == 2'b00);
  assign w_is_dmem = w_hi_ok && (w_a[11] == DMEM_BASE[11]);
  assign w_is_hex  = w_slot_ok && (w_a[11:7] == HEX_BASE[11:7]) && (32'(w_a[6:4]) < NUM_HEX);
  assign w_is_ledr = w_slot_ok && (w_a[11:4] == LEDR_ADDR[11:4]);
  assign w_is_ledg = w_slot_ok && (w_a[11:4] == LEDG_ADDR[11:4]);
  assign w_is_lcd  = w_slot_ok && (w_a[11:4] == LCD_ADDR[11:4]);
  assign w_is_sw   = w_slot_ok && (w_a[11:4] == SW_ADDR[11:4]);
  assign w_is_keys = w_slot_ok && (w_a[11:4] == KEYS_ADDR[11:4]);
  assign w_mapped  = w_is_dmem | w_is_hex | w_is_ledr | w_is_ledg | w_is_lcd | w_is_sw | w_is_keys;

  assign w_fault = !w_misalign &&
                   (!w_mapped || w_illegal || (st_en_i && (w_is_sw || w_is_keys)));
  assign w_we    = st_en_i && !w_misalign && !w_fault;
  assign w_be    = byte_en(w_f3, w_a[1:0]);
  assign w_wdata = st_replicate(w_f3, st_data_i);

  lsu_dmem #(
    .WORDS (DMEM_WORDS),
    .IDX_W (IDX_W)
  ) u_dmem (
    .clk     (clk),
    .i_idx   (w_a[IDX_W+1:2]),
    .i_be    ((w_we && w_is_dmem) ? w_be : 4'b0000),
    .i_wdata (w_wdata),
    .o_rdata (w_dmem_rdata)
  );

  always_comb begin
    w_io_rdata = '0;
    for (int k = 0; k < NUM_HEX; k++) begin
      if (w_is_hex && (w_a[6:4] == 3'(k))) w_io_rdata = r_hex[k];
    end
    if (w_is_ledr) w_io_rdata = r_ledr;
    if (w_is_ledg) w_io_rdata = r_ledg;
    if (w_is_lcd)  w_io_rdata = r_lcd;
    if (w_is_sw)   w_io_rdata = r_sw_sync[SYNC_STAGES-1];
    if (w_is_keys) w_io_rdata = r_keys_sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_HEX; k++) r_hex[k] <= '0;
      r_ledr <= '0;
      r_ledg <= '0;
      r_lcd  <= '0;
    end else begin
      for (int k = 0; k < NUM_HEX; k++) begin
        if (w_we && w_is_hex && (w_a[6:4] == 3'(k))) r_hex[k] <= be_merge(r_hex[k], w_wdata, w_be);
      end
      if (w_we && w_is_ledr) r_ledr <= be_merge(r_ledr, w_wdata, w_be);
      if (w_we && w_is_ledg) r_ledg <= be_merge(r_ledg, w_wdata, w_be);
      if (w_we && w_is_lcd)  r_lcd  <= be_merge(r_lcd, w_wdata, w_be);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sw_sync[s]   <= '0;
        r_keys_sync[s] <= '0;
      end
    end else begin
      r_sw_sync[0]   <= io_sw_i;
      r_keys_sync[0] <= io_keys_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sw_sync[s]   <= r_sw_sync[s-1];
        r_keys_sync[s] <= r_keys_sync[s-1];
      end
    end
  end

  // DMEM read data is already registered inside the RAM, so only the lane/size
  // controls and the IO read value are captured here; extension happens after.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
      r_ld_zero  <= 1'b1;
      r_ld_dmem  <= 1'b0;
      r_ld_f3    <= 3'b000;
      r_ld_lo    <= 2'b00;
      r_io_rdata <= '0;
    end else begin
      r_misalign <= w_misalign;
      r_fault    <= w_fault;
      r_ld_zero  <= w_misalign || w_fault;
      r_ld_dmem  <= w_is_dmem;
      r_ld_f3    <= w_f3;
      r_ld_lo    <= w_a[1:0];
      r_io_rdata <= w_io_rdata;
    end
  end

  assign w_ld_word  = r_ld_dmem ? w_dmem_rdata : r_io_rdata;
  assign ld_data_o  = r_ld_zero ? '0 : ld_extend(w_ld_word, r_ld_f3, r_ld_lo);
  assign misalign_o = r_misalign;
  assign fault_o    = r_fault;

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex_out
    assign io_hex_o[32*k +: 32] = r_hex[k];
  end
  assign io_ledr_o = r_ledr;
  assign io_ledg_o = r_ledg;
  assign io_lcd_o  = r_lcd;

endmodule

// File: tb/tb_lsu_mmio.sv
// Randomised and directed check of lsu_mmio against a byte-level memory-map model.
module tb_lsu_mmio;

  localparam int NH   = 4;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [11:0]     addr_i;
  logic [2:0]      ld_st_sel_i;
  logic            st_en_i;
  logic [31:0]     st_data_i;
  logic [31:0]     ld_data_o;
  logic            misalign_o;
  logic            fault_o;
  logic [31:0]     io_sw_i;
  logic [31:0]     io_keys_i;
  logic [NH*32-1:0] io_hex_o;
  logic [31:0]     io_ledr_o;
  logic [31:0]     io_ledg_o;
  logic [31:0]     io_lcd_o;

  always #5 clk = ~clk;

  lsu_mmio #(
    .ADDR_W      (12),
    .DMEM_WORDS  (512),
    .NUM_HEX     (NH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .addr_i      (addr_i),
    .ld_st_sel_i (ld_st_sel_i),
    .st_en_i     (st_en_i),
    .st_data_i   (st_data_i),
    .ld_data_o   (ld_data_o),
    .misalign_o  (misalign_o),
    .fault_o     (fault_o),
    .io_sw_i     (io_sw_i),
    .io_keys_i   (io_keys_i),
    .io_hex_o    (io_hex_o),
    .io_ledr_o   (io_ledr_o),
    .io_ledg_o   (io_ledg_o),
    .io_lcd_o    (io_lcd_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_mem [512];
  logic [31:0] m_hex [NH];
  logic [31:0] m_ledr, m_ledg, m_lcd;
  logic [31:0] sw_val, sw_prev, keys_val, keys_prev;
  int          sw_edges, keys_edges;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sw_seen();
    return (sw_edges >= SYNC) ? sw_val : sw_prev;
  endfunction

  function automatic logic [31:0] keys_seen();
    return (keys_edges >= SYNC) ? keys_val : keys_prev;
  endfunction

  task automatic set_sw(input logic [31:0] v);
    sw_prev  = sw_seen();
    sw_val   = v;
    sw_edges = 0;
    io_sw_i  = v;
  endtask

  task automatic set_keys(input logic [31:0] v);
    keys_prev  = keys_seen();
    keys_val   = v;
    keys_edges = 0;
    io_keys_i  = v;
  endtask

  // 0 unmapped, 1 dmem, 2 hex, 3 ledr, 4 ledg, 5 lcd, 6 sw, 7 keys
  function automatic int region(input int a);
    int slot;
    if (a < 'h800) return 1;
    if ((a % 16) >= 4) return 0;
    slot = a / 16;
    if (slot >= 'h80 && slot < 'h80 + NH) return 2;
    if (slot == 'h88) return 3;
    if (slot == 'h89) return 4;
    if (slot == 'h8A) return 5;
    if (slot == 'h90) return 6;
    if (slot == 'h91) return 7;
    return 0;
  endfunction

  function automatic logic [31:0] get_word(input int rg, input int a);
    case (rg)
      1: return m_mem[(a / 4) % 512];
      2: return m_hex[a / 16 - 'h80];
      3: return m_ledr;
      4: return m_ledg;
      5: return m_lcd;
      6: return sw_seen();
      7: return keys_seen();
      default: return 32'h0;
    endcase
  endfunction

  task automatic put_word(input int rg, input int a, input logic [31:0] w);
    case (rg)
      1: m_mem[(a / 4) % 512] = w;
      2: m_hex[a / 16 - 'h80] = w;
      3: m_ledr = w;
      4: m_ledg = w;
      5: m_lcd = w;
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check_val("ledr", io_ledr_o, m_ledr);
    check_val("ledg", io_ledg_o, m_ledg);
    check_val("lcd", io_lcd_o, m_lcd);
    for (int k = 0; k < NH; k++) check_val($sformatf("hex%0d", k), io_hex_o[32*k +: 32], m_hex[k]);
  endtask

  task automatic step(input int a, input int f3, input bit st, input logic [31:0] d);
    int nb, lo, rg;
    bit legal, mis, flt;
    logic [31:0] word, exp_ld;
    longint unsigned msk, v;
    addr_i      = a[11:0];
    ld_st_sel_i = f3[2:0];
    st_en_i     = st;
    st_data_i   = d;
    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    nb    = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    lo    = a % 4;
    mis   = legal && (a % nb != 0);
    rg    = region(a);
    flt   = !mis && (!legal || rg == 0 || (st && f3 >= 4) || (st && rg >= 6));
    word  = get_word(rg, a);
    msk   = (64'd1 << (8 * nb)) - 1;
    v     = ({32'b0, word} >> (8 * lo)) & msk;
    if (f3 < 4 && nb < 4 && v[8*nb-1]) v = v | ~msk;
    exp_ld = (mis || flt) ? 32'h0 : v[31:0];
    @(posedge clk);
    if (st && !mis && !flt) begin
      for (int j = 0; j < nb; j++) word[8*(lo+j) +: 8] = d[8*j +: 8];
      put_word(rg, a, word);
    end
    sw_edges++;
    keys_edges++;
    #1;
    check_val("ld_data", ld_data_o, exp_ld);
    check_val("misalign", {31'b0, misalign_o}, {31'b0, mis});
    check_val("fault", {31'b0, fault_o}, {31'b0, flt});
    check_outputs();
  endtask

  initial begin
    int a, f3, kind;
    int legal_f3 [5] = '{0, 1, 2, 4, 5};
    rst_ni = 1'b0;
    addr_i = '0; ld_st_sel_i = '0; st_en_i = 1'b0; st_data_i = '0;
    io_sw_i = '0; io_keys_i = '0;
    sw_val = '0; sw_prev = '0; keys_val = '0; keys_prev = '0;
    sw_edges = 0; keys_edges = 0;
    m_ledr = '0; m_ledg = '0; m_lcd = '0;
    for (int k = 0; k < NH; k++) m_hex[k] = '0;

    #12;
    check_val("rst_ld", ld_data_o, 32'h0);
    check_val("rst_mis", {31'b0, misalign_o}, 32'h0);
    check_val("rst_flt", {31'b0, fault_o}, 32'h0);
    check_outputs();
    rst_ni = 1'b1;

    // Give every DMEM word a known value
    for (int w = 0; w < 512; w++) step(w * 4, 2, 1'b1, $urandom);

    // 1: word store / load
    step('h004, 2, 1'b1, 32'hDEADBEEF);
    step('h004, 2, 1'b0, 32'h0);
    check_val("t1_lw", ld_data_o, 32'hDEADBEEF);

    // 2: byte store into a word, then sign/zero-extended sub-word loads
    step('h010, 2, 1'b1, 32'h11223344);
    step('h011, 0, 1'b1, 32'h000000A5);
    step('h010, 2, 1'b0, 32'h0);
    check_val("t2_lw", ld_data_o, 32'h1122A544);
    step('h011, 0, 1'b0, 32'h0);
    check_val("t2_lb", ld_data_o, 32'hFFFFFFA5);
    step('h011, 4, 1'b0, 32'h0);
    check_val("t2_lbu", ld_data_o, 32'h000000A5);
    step('h012, 5, 1'b0, 32'h0);
    check_val("t2_lhu", ld_data_o, 32'h00001122);

    // 3: misalignment
    step('h006, 2, 1'b0, 32'h0);
    check_val("t3_mis", {31'b0, misalign_o}, 32'h1);
    step('h003, 1, 1'b1, 32'h0000FFFF);
    step('h000, 2, 1'b0, 32'h0);

    // 4: IO output registers, including HEX slots beyond NUM_HEX
    for (int k = 0; k < 8; k++) begin
      step('h800 + 16 * k, 2, 1'b1, 32'hA0B0C000 + k);
      check_val("t4_hexflt", {31'b0, fault_o}, (k >= NH) ? 32'h1 : 32'h0);
      step('h800 + 16 * k, 2, 1'b0, 32'h0);
    end
    step('h880, 2, 1'b1, 32'h13579BDF);
    step('h890, 2, 1'b1, 32'h2468ACE0);
    step('h8A0, 2, 1'b1, 32'h0F1E2D3C);
    check_val("t4_lcd", io_lcd_o, 32'h0F1E2D3C);
    step('h880, 2, 1'b0, 32'h0);
    check_val("t4_ledr_rb", ld_data_o, 32'h13579BDF);
    step('h891, 1, 1'b1, 32'h0000BEEF);
    step('h8A2, 5, 1'b0, 32'h0);

    // 5: switch synchroniser latency and read-only inputs
    step('h900, 2, 1'b0, 32'h0);
    set_sw(32'h12345678);
    set_keys(32'hCAFEF00D);
    step('h900, 2, 1'b0, 32'h0);
    step('h900, 2, 1'b0, 32'h0);
    step('h900, 2, 1'b0, 32'h0);
    check_val("t5_sw", ld_data_o, 32'h12345678);
    step('h910, 2, 1'b1, 32'hFFFFFFFF);
    check_val("t5_keysflt", {31'b0, fault_o}, 32'h1);
    step('h910, 2, 1'b0, 32'h0);
    check_val("t5_keys", ld_data_o, 32'hCAFEF00D);

    // Random mix over the whole map
    for (int i = 0; i < 600; i++) begin
      if (i % 8 == 0) begin
        set_sw($urandom);
        set_keys($urandom);
      end
      kind = $urandom_range(0, 3);
      case (kind)
        0: a = $urandom_range(0, 'h7FF);
        1, 2: a = 'h800 + 16 * $urandom_range(0, 17) +
                  (($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
        default: a = $urandom_range(0, 'hFFF);
      endcase
      f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : $urandom_range(0, 7);
      step(a, f3, 1'($urandom_range(0, 1)), $urandom);
    end

    // 6: asynchronous reset mid-cycle, and a store lost under reset
    step('h880, 2, 1'b1, 32'hFFFFFFFF);
    #3 rst_ni = 1'b0;
    #1;
    check_val("t6_ledr_async", io_ledr_o, 32'h0);
    check_val("t6_ld_async", ld_data_o, 32'h0);
    check_val("t6_flt_async", {31'b0, fault_o}, 32'h0);
    addr_i = 12'h880; ld_st_sel_i = 3'b010; st_en_i = 1'b1; st_data_i = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    m_ledr = '0; m_ledg = '0; m_lcd = '0;
    for (int k = 0; k < NH; k++) m_hex[k] = '0;
    sw_prev = '0; sw_edges = 0; keys_prev = '0; keys_edges = 0;
    check_outputs();
    step('hA00, 2, 1'b0, 32'h0);
    check_val("t6_unmapped_flt", {31'b0, fault_o}, 32'h1);
    check_val("t6_unmapped_ld", ld_data_o, 32'h0);
    step('h900, 2, 1'b0, 32'h0);
    step('h900, 2, 1'b0, 32'h0);
    step('h900, 2, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
